// File: rtl/uart_pkg.sv
// Shared types and constants for the follower-link UART receiver.
// Imported by the sampler and the receiver top.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line conditioning: synchroniser, start-edge detect and
// three-sample majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 2604,
    localparam int CW = cnt_w(CLK_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RX,
    input  logic [CW-1:0] cnt,
    output logic          rxs,
    output logic          fall,
    output logic          bit_val,
    output logic          bit_valid
);

    localparam int HALF = CLK_DIV / 2;
    localparam logic [CW-1:0] SMP_A = CW'(HALF - 1);
    localparam logic [CW-1:0] SMP_B = CW'(HALF);
    localparam logic [CW-1:0] SMP_C = CW'(HALF + 1);

    logic       s1;
    logic       s2;
    logic       rxs_d;
    logic [1:0] fill;
    logic       smp_a;
    logic       smp_b;

    assign rxs = s2;

    // synchroniser and edge history; fill counts edges until history holds real line data
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            rxs_d <= 1'b1;
            fill  <= 2'd0;
        end else begin
            s1    <= RX;
            s2    <= s1;
            rxs_d <= s2;
            if (fill != 2'd3)
                fill <= fill + 2'd1;
        end
    end

    // capture the first two of the three centre samples
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else begin
            if (cnt == SMP_A)
                smp_a <= s2;
            if (cnt == SMP_B)
                smp_b <= s2;
        end
    end

    // edge detect and majority decision on the third sample
    always_comb begin
        fall      = (fill == 2'd3) && rxs_d && !s2;
        bit_valid = (cnt == SMP_C);
        bit_val   = (smp_a & smp_b) | (smp_a & s2) | (smp_b & s2);
    end

endmodule

// File: rtl/uart_rcv_cfg.sv
// Configurable UART receiver: frame FSM, shift register, parity,
// error flags and the rx_rdy / clr_rx_rdy consumer handshake.
module uart_rcv_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 2604,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_rx_rdy,
    output logic                 rx_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = cnt_w(CLK_DIV);
    localparam int IW = cnt_w(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_DATA = IW'(DATA_BITS);
    localparam logic [IW-1:0] IDX_STOP = IW'(STOP_BITS - 1);

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 par_bit, par_n;
    logic                 ferr_p, ferr_n;
    logic                 done;
    logic                 wrap;
    logic                 par_x;
    logic                 perr_c;
    logic                 rxs;
    logic                 fall;
    logic                 bit_val;
    logic                 bit_valid;

    uart_rx_sampler #(
        .CLK_DIV(CLK_DIV)
    ) u_smp (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .cnt      (cnt),
        .rxs      (rxs),
        .fall     (fall),
        .bit_val  (bit_val),
        .bit_valid(bit_valid)
    );

    assign wrap = (cnt == CNT_MAX);

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next state, bit timing and data capture
    always_comb begin
        state_n = state;
        cnt_n   = wrap ? '0 : cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        par_n   = par_bit;
        ferr_n  = ferr_p;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall && !rxs) begin
                    state_n = START;
                    ferr_n  = 1'b0;
                end
            end
            START: begin
                if (bit_valid && bit_val) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (wrap) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    sh_n  = {bit_val, sh[DATA_BITS-1:1]};
                    idx_n = idx + 1'b1;
                end
                if (wrap && idx == IDX_DATA) begin
                    state_n = (PARITY != PARITY_NONE) ? PAR : STOP;
                    idx_n   = '0;
                end
            end
            PAR: begin
                if (bit_valid)
                    par_n = bit_val;
                if (wrap) begin
                    state_n = STOP;
                    idx_n   = '0;
                end
            end
            STOP: begin
                if (bit_valid) begin
                    if (!bit_val)
                        ferr_n = 1'b1;
                    if (idx == IDX_STOP) begin
                        done    = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // parity check over data plus received parity bit
    always_comb begin
        par_x  = ^sh ^ par_bit;
        perr_c = 1'b0;
        if (PARITY == PARITY_ODD)
            perr_c = ~par_x;
        else if (PARITY == PARITY_EVEN)
            perr_c = par_x;
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            par_bit <= 1'b0;
            ferr_p  <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            idx     <= idx_n;
            sh      <= sh_n;
            par_bit <= par_n;
            ferr_p  <= ferr_n;
        end
    end

    // frame delivery and handshake; completion beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rdy     <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            rx_rdy     <= 1'b1;
            rx_data    <= sh;
            parity_err <= perr_c;
            frame_err  <= ferr_n;
            overrun    <= !clr_rx_rdy && (overrun || rx_rdy);
        end else if (clr_rx_rdy) begin
            rx_rdy  <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rcv_cfg.sv
// Scoreboard bench for uart_rcv_cfg: one instance without parity,
// one with even parity, both at 16 clocks per bit.
module tb_uart_rcv_cfg;
    import uart_pkg::*;

    localparam int DIV = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] clr = 2'b00;
    logic [1:0] rx  = 2'b11;
    logic [1:0] rdy;
    logic [1:0] pe;
    logic [1:0] fe;
    logic [1:0] ov;
    logic [7:0] dat [2];

    exp_t sb [2][$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_rcv_cfg #(
        .CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u0 (
        .clk(clk), .rst(rst), .RX(rx[0]), .clr_rx_rdy(clr[0]),
        .rx_rdy(rdy[0]), .rx_data(dat[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .overrun(ov[0])
    );

    uart_rcv_cfg #(
        .CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) u2 (
        .clk(clk), .rst(rst), .RX(rx[1]), .clr_rx_rdy(clr[1]),
        .rx_rdy(rdy[1]), .rx_data(dat[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .overrun(ov[1])
    );

    // monitor: a new frame is rx_rdy rising, new data, or overrun rising
    logic [1:0] p_rdy;
    logic [1:0] p_ov;
    logic [7:0] p_dat [2];
    exp_t       m_e;
    exp_t       m_a;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                p_rdy[i] = 1'b0;
                p_ov[i]  = 1'b0;
                p_dat[i] = 8'h00;
            end else begin
                if (rdy[i] && (!p_rdy[i] || dat[i] != p_dat[i] ||
                               (ov[i] && !p_ov[i]))) begin
                    total++;
                    m_a = {dat[i], pe[i], fe[i], ov[i]};
                    if (sb[i].size() == 0) begin
                        bad++;
                        $display("FAIL frame%0d unexpected got d=%h pe=%b fe=%b ov=%b",
                                 i, m_a.d, m_a.pe, m_a.fe, m_a.ov);
                    end else begin
                        m_e = sb[i].pop_front();
                        if (m_a !== m_e) begin
                            bad++;
                            $display("FAIL frame%0d got d=%h pe=%b fe=%b ov=%b want d=%h pe=%b fe=%b ov=%b",
                                     i, m_a.d, m_a.pe, m_a.fe, m_a.ov,
                                     m_e.d, m_e.pe, m_e.fe, m_e.ov);
                        end
                    end
                end
                p_rdy[i] = rdy[i];
                p_ov[i]  = ov[i];
                p_dat[i] = dat[i];
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic expect_frame(input int i, input logic [7:0] d,
                                input logic p, input logic f,
                                input logic o);
        exp_t e;
        e.d  = d;
        e.pe = p;
        e.fe = f;
        e.ov = o;
        sb[i].push_back(e);
    endtask

    task automatic tx_bit(input int i, input logic v, input bit spk);
        rx[i] = v;
        if (spk) begin
            step(8);
            rx[i] = ~v;
            step(1);
            rx[i] = v;
            step(7);
        end else begin
            step(DIV);
        end
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic pb,
                        input logic sv, input int spk_bit);
        tx_bit(i, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++)
            tx_bit(i, d[b], b == spk_bit);
        if (i == 1)
            tx_bit(i, pb, 1'b0);
        tx_bit(i, sv, 1'b0);
        rx[i] = 1'b1;
    endtask

    task automatic pulse_clr(input int i);
        clr[i] = 1'b1;
        step(1);
        clr[i] = 1'b0;
        @(negedge clk);
        chk($sformatf("clr_rdy%0d", i), 32'(rdy[i]), 0);
        chk($sformatf("clr_ov%0d", i), 32'(ov[i]), 0);
        step(1);
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_rdy"}, 32'(rdy[i]), 0);
        chk({tag, "_data"}, 32'(dat[i]), 0);
        chk({tag, "_perr"}, 32'(pe[i]), 0);
        chk({tag, "_ferr"}, 32'(fe[i]), 0);
        chk({tag, "_ovr"}, 32'(ov[i]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        bit         seen;

        rst = 1'b1;
        step(3);
        @(negedge clk);
        chk_zero(0, "rst0");
        chk_zero(1, "rst2");
        step(1);
        rst = 1'b0;
        step(4);

        expect_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        send(0, 8'hA5, 1'b0, 1'b1, -1);
        step(4);
        pulse_clr(0);

        expect_frame(1, 8'h03, 1'b1, 1'b0, 1'b0);
        send(1, 8'h03, 1'b1, 1'b1, -1);
        step(4);
        pulse_clr(1);
        expect_frame(1, 8'h03, 1'b0, 1'b0, 1'b0);
        send(1, 8'h03, 1'b0, 1'b1, -1);
        step(4);
        pulse_clr(1);

        expect_frame(0, 8'h55, 1'b0, 1'b1, 1'b0);
        send(0, 8'h55, 1'b0, 1'b0, -1);
        step(4);
        pulse_clr(0);
        expect_frame(0, 8'h0F, 1'b0, 1'b0, 1'b0);
        send(0, 8'h0F, 1'b0, 1'b1, -1);
        step(4);
        pulse_clr(0);

        expect_frame(0, 8'h00, 1'b0, 1'b1, 1'b0);
        rx[0] = 1'b0;
        step(12 * DIV);
        rx[0] = 1'b1;
        step(2 * DIV);
        pulse_clr(0);

        rx[0] = 1'b0;
        step(3);
        rx[0] = 1'b1;
        step(3 * DIV);
        @(negedge clk);
        chk("glitch_rdy", 32'(rdy[0]), 0);
        chk("glitch_idle", 32'(u0.state), 32'(IDLE));
        step(1);

        expect_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(0, 8'h00, 1'b0, 1'b1, 2);
        step(4);
        pulse_clr(0);

        expect_frame(0, 8'h11, 1'b0, 1'b0, 1'b0);
        expect_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        send(0, 8'h11, 1'b0, 1'b1, -1);
        send(0, 8'h22, 1'b0, 1'b1, -1);
        step(4);
        @(negedge clk);
        chk("ovr_flag", 32'(ov[0]), 1);
        chk("ovr_data", 32'(dat[0]), 32'h22);
        step(1);
        pulse_clr(0);

        expect_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        send(0, 8'h3C, 1'b0, 1'b1, -1);
        step(4);
        pat = 8'h99;
        tx_bit(0, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++)
            tx_bit(0, pat[b], 1'b0);
        rx[0] = pat[4];
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk_zero(0, "midrst");
        step(1);
        rx[0] = 1'b1;
        step(3 * DIV);
        expect_frame(0, 8'h7E, 1'b0, 1'b0, 1'b0);
        send(0, 8'h7E, 1'b0, 1'b1, -1);
        step(4);

        expect_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        clr[0] = 1'b1;
        fork
            send(0, 8'h5A, 1'b0, 1'b1, -1);
            begin
                seen = 1'b0;
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (!rdy[0]) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("coinc_drop", 32'(seen), 1);
                seen = 1'b0;
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (rdy[0]) begin
                        seen = 1'b1;
                        break;
                    end
                end
                clr[0] = 1'b0;
                chk("coinc_rise", 32'(seen), 1);
            end
        join
        @(negedge clk);
        chk("coinc_rdy", 32'(rdy[0]), 1);
        chk("coinc_ovr", 32'(ov[0]), 0);
        step(1);
        pulse_clr(0);

        step(DIV);
        chk("left0", 32'(sb[0].size()), 0);
        chk("left2", 32'(sb[1].size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
